// File: rtl/skinny_sbox8_isw_pini_iter_if.sv
// Handshake, share and randomness buses of the masked SKINNY-128 S-box engine.
// SKINNY_SBOX_OUT_REFRESH_EN adds the rnd_ref output-refresh randomness bus.
interface skinny_sbox8_isw_pini_iter_if #(
    parameter int SHARES = 2,
    parameter int NBYTES = 1
);
    localparam int RPG = SHARES * (SHARES - 1) / 2;
    localparam int RW  = NBYTES * 2 * RPG;
    localparam int SW  = SHARES * NBYTES * 8;

    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sh;
    logic [RW-1:0] rnd;
    logic          rnd_req;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sh;
    logic          busy;
`ifdef SKINNY_SBOX_OUT_REFRESH_EN
    logic [NBYTES*8*(SHARES-1)-1:0] rnd_ref;

    modport slave (
        input  in_valid, in_sh, rnd, out_ready, rnd_ref,
        output in_ready, rnd_req, out_valid, out_sh, busy
    );
    modport master (
        output in_valid, in_sh, rnd, out_ready, rnd_ref,
        input  in_ready, rnd_req, out_valid, out_sh, busy
    );
`else
    modport slave (
        input  in_valid, in_sh, rnd, out_ready,
        output in_ready, rnd_req, out_valid, out_sh, busy
    );
    modport master (
        output in_valid, in_sh, rnd, out_ready,
        input  in_ready, rnd_req, out_valid, out_sh, busy
    );
`endif
endinterface

// File: rtl/skinny_sbox8_isw_pini_iter.sv
// Masked SKINNY-128 S8 (SHARES shares, NBYTES lanes), one NOR layer per MUL/CMP pair; optional SKINNY_SBOX_OUT_REFRESH_EN.
// out_valid 8 clocks after accept; result held in HOLD until out_ready, in_ready low whenever busy.
module skinny_sbox8_isw_pini_iter #(
    parameter int SHARES = 2,
    parameter int NBYTES = 1
) (
    input logic                         clk,
    input logic                         rst_n,
    skinny_sbox8_isw_pini_iter_if.slave bus
);
    localparam int RPG = SHARES * (SHARES - 1) / 2;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_CMP, ST_HOLD} state_t;

    state_t r_state, w_state_nxt;
    logic [1:0] r_layer;
    logic [SHARES-1:0][NBYTES-1:0][7:0] r_sh, r_out, w_sh_nxt, w_ref;
    logic [NBYTES-1:0][1:0][SHARES-1:0][SHARES-1:0] r_prod, w_prod;
    logic [NBYTES-1:0][1:0][SHARES-1:0] w_op_a, w_op_b, w_cmp;

    function automatic int pair_idx(input int i, input int j);
        return i * SHARES - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic logic [7:0] layer_perm(input logic [7:0] x, input logic last);
        return last ? {x[7:3], x[1], x[2], x[0]}
                    : {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = ST_MUL;
            ST_MUL:  w_state_nxt = ST_CMP;
            ST_CMP:  w_state_nxt = (r_layer == 2'd3) ? ST_HOLD : ST_MUL;
            ST_HOLD: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_HOLD);
        bus.busy      = (r_state != ST_IDLE);
        bus.rnd_req   = (r_state == ST_MUL);
`ifdef SKINNY_SBOX_OUT_REFRESH_EN
        if (r_state == ST_CMP && r_layer == 2'd3) bus.rnd_req = 1'b1;
`endif
    end

    assign bus.out_sh = r_out;

    // NOR(a,b) = ~a & ~b: complementing share 0 alone complements the shared value.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int b = 0; b < NBYTES; b++) begin
            for (int k = 0; k < SHARES; k++) begin
                w_op_a[b][0][k] = r_sh[k][b][7] ^ (k == 0);
                w_op_b[b][0][k] = r_sh[k][b][6] ^ (k == 0);
                w_op_a[b][1][k] = r_sh[k][b][3] ^ (k == 0);
                w_op_b[b][1][k] = r_sh[k][b][2] ^ (k == 0);
            end
        end
    end

    // Both halves of an off-diagonal pair share one random bit, so it cancels in the share XOR.
    always_comb begin
        w_prod = '0;
        for (int b = 0; b < NBYTES; b++) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < SHARES; i++) begin
                    for (int j = 0; j < SHARES; j++) begin
                        w_prod[b][g][i][j] = w_op_a[b][g][i] & w_op_b[b][g][j];
                        if (i != j)
                            w_prod[b][g][i][j] = w_prod[b][g][i][j] ^ bus.rnd[(b*2+g)*RPG +
                                ((i < j) ? pair_idx(i, j) : pair_idx(j, i))];
                    end
                end
            end
        end
    end

    always_comb begin
        w_cmp    = '0;
        w_sh_nxt = '0;
        for (int b = 0; b < NBYTES; b++) begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < SHARES; i++) begin
                    w_cmp[b][g][i] = ^r_prod[b][g][i];
                end
            end
            for (int k = 0; k < SHARES; k++) begin
                w_sh_nxt[k][b] = layer_perm(r_sh[k][b] ^ {3'b000, w_cmp[b][0][k], 3'b000, w_cmp[b][1][k]},
                                            r_layer == 2'd3);
            end
        end
    end

`ifdef SKINNY_SBOX_OUT_REFRESH_EN
    always_comb begin
        w_ref = '0;
        for (int k = 1; k < SHARES; k++) begin
            w_ref[k] = bus.rnd_ref[(k-1)*NBYTES*8 +: NBYTES*8];
            w_ref[0] = w_ref[0] ^ bus.rnd_ref[(k-1)*NBYTES*8 +: NBYTES*8];
        end
    end
`else
    assign w_ref = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh    <= '0;
            r_prod  <= '0;
            r_out   <= '0;
            r_layer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sh    <= bus.in_sh;
                        r_layer <= '0;
                    end
                end
                ST_MUL: r_prod <= w_prod;
                ST_CMP: begin
                    r_sh <= w_sh_nxt;
                    if (r_layer == 2'd3) r_out   <= w_sh_nxt ^ w_ref;
                    else                 r_layer <= r_layer + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_skinny_sbox8_isw_pini_iter.sv
// Directed bench for the masked SKINNY S8 engine: a 2-share/1-byte and a 3-share/16-byte instance.
module tb_skinny_sbox8_isw_pini_iter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef SKINNY_SBOX_OUT_REFRESH_EN
    localparam int EXP_REQ = 5;
`else
    localparam int EXP_REQ = 4;
`endif

    always #5 clk = ~clk;

    skinny_sbox8_isw_pini_iter_if #(.SHARES(2), .NBYTES(1))  a_if ();
    skinny_sbox8_isw_pini_iter_if #(.SHARES(3), .NBYTES(16)) b_if ();

    skinny_sbox8_isw_pini_iter #(.SHARES(2), .NBYTES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    skinny_sbox8_isw_pini_iter #(.SHARES(3), .NBYTES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    // Reference S8 written in the bitsliced mix/permute/swap form of the cipher definition.
    function automatic logic [7:0] sbox_ref(input logic [7:0] xin);
        logic [7:0] x;
        x = xin;
        for (int r = 0; r < 4; r++) begin
            x = x ^ ((~(((x >> 1) | x) >> 2)) & 8'h11);
            if (r < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                    ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [7:0] x, input logic [7:0] m, input bit zero_rnd, input bit hold,
                         output logic [15:0] sh, output int lat);
        a_if.in_sh     = {x ^ m, m};
        a_if.in_valid  = 1'b1;
        a_if.out_ready = !hold;
        a_if.rnd       = zero_rnd ? 2'b00 : 2'($urandom);
        tick();
        a_if.in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            a_if.rnd = zero_rnd ? 2'b00 : 2'($urandom);
            tick();
            if (a_if.out_valid) begin
                lat = c;
                break;
            end
        end
        sh = a_if.out_sh;
        if (!hold) tick();
    endtask

    task automatic test_reset();
        checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_if.in_ready); end
        checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_if.out_valid); end
        checks++; if (a_if.rnd_req !== 1'b0) begin errors++; $display("FAIL reset_rnd_req: got %b want 0", a_if.rnd_req); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_if.busy); end
        checks++; if (a_if.out_sh !== 16'h0000) begin errors++; $display("FAIL reset_out_sh: got %h want 0000", a_if.out_sh); end
        checks++; if (b_if.busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_if.busy); end
        checks++; if (b_if.out_sh !== '0) begin errors++; $display("FAIL reset_b_out_sh: nonzero %h", b_if.out_sh); end
    endtask

    task automatic test_lut_row();
        logic [7:0]  row [16] = '{8'h65, 8'h4c, 8'h6a, 8'h42, 8'h4b, 8'h63, 8'h43, 8'h6b,
                                  8'h55, 8'h75, 8'h5a, 8'h7a, 8'h53, 8'h73, 8'h5b, 8'h7b};
        logic [15:0] sh;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            run_a(8'(i), 8'($urandom), 1'b0, 1'b0, sh, lat);
            checks++;
            if ((sh[15:8] ^ sh[7:0]) !== row[i]) begin
                errors++; $display("FAIL lut_row x=%h: got %h want %h", i, sh[15:8] ^ sh[7:0], row[i]);
            end
        end
        run_a(8'hFF, 8'($urandom), 1'b0, 1'b0, sh, lat);
        checks++; if ((sh[15:8] ^ sh[7:0]) !== 8'hFF) begin errors++; $display("FAIL lut_ff: got %h want ff", sh[15:8] ^ sh[7:0]); end
    endtask

    task automatic test_sweep();
        logic [15:0] sh;
        int          lat;
        for (int i = 0; i < 256; i++) begin
            run_a(8'(i), 8'($urandom), 1'b0, 1'b0, sh, lat);
            checks++;
            if ((sh[15:8] ^ sh[7:0]) !== sbox_ref(8'(i))) begin
                errors++; $display("FAIL sweep x=%h: got %h want %h", i, sh[15:8] ^ sh[7:0], sbox_ref(8'(i)));
            end
            checks++; if (lat !== 8) begin errors++; $display("FAIL latency x=%h: got %0d want 8", i, lat); end
        end
    endtask

    task automatic test_wide();
        logic [2:0][15:0][7:0] sh_in, sh_out;
        logic [7:0]            got, exp;
        int                    pulses;
        bit                    seen;
        for (int op = 0; op < 2; op++) begin
            for (int s = 0; s < 3; s++)
                for (int k = 0; k < 16; k++) sh_in[s][k] = 8'($urandom);
            b_if.in_sh     = sh_in;
            b_if.in_valid  = 1'b1;
            b_if.out_ready = 1'b1;
            b_if.rnd       = {$urandom, $urandom, $urandom};
            tick();
            b_if.in_valid = 1'b0;
            pulses = 0;
            seen   = 1'b0;
            for (int c = 1; c <= 40 && !seen; c++) begin
                if (b_if.rnd_req) pulses++;
                b_if.rnd = {$urandom, $urandom, $urandom};
                tick();
                if (b_if.out_valid) seen = 1'b1;
            end
            checks++; if (!seen) begin errors++; $display("FAIL wide_timeout op=%0d: out_valid never rose", op); end
            checks++; if (pulses !== EXP_REQ) begin errors++; $display("FAIL wide_rnd_req op=%0d: got %0d want %0d", op, pulses, EXP_REQ); end
            checks++; if (b_if.rnd_req !== 1'b0) begin errors++; $display("FAIL wide_rnd_req_hold: got %b want 0", b_if.rnd_req); end
            sh_out = b_if.out_sh;
            for (int k = 0; k < 16; k++) begin
                got = sh_out[0][k] ^ sh_out[1][k] ^ sh_out[2][k];
                exp = sbox_ref(sh_in[0][k] ^ sh_in[1][k] ^ sh_in[2][k]);
                checks++; if (got !== exp) begin errors++; $display("FAIL wide_byte op=%0d b=%0d: got %h want %h", op, k, got, exp); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] sh;
        int          lat;
        int          bad_stable = 0;
        int          bad_ready  = 0;
        run_a(8'h3C, 8'hA5, 1'b0, 1'b1, sh, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", lat); end
        for (int c = 0; c < 20; c++) begin
            a_if.in_valid = c[0];
            a_if.in_sh    = 16'($urandom);
            a_if.rnd      = 2'($urandom);
            tick();
            if (a_if.out_sh !== sh || a_if.out_valid !== 1'b1) bad_stable++;
            if (a_if.in_ready !== 1'b0) bad_ready++;
        end
        checks++; if (bad_stable !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad_stable); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL bp_in_ready: %0d ready cycles want 0", bad_ready); end
        checks++; if ((sh[15:8] ^ sh[7:0]) !== sbox_ref(8'h3C)) begin errors++; $display("FAIL bp_value: got %h want %h", sh[15:8] ^ sh[7:0], sbox_ref(8'h3C)); end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", a_if.out_valid); end
        checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", a_if.in_ready); end
        tick();
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept: busy %b want 0", a_if.busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] sh;
        int          lat;
        int          spurious = 0;
        a_if.in_sh     = {8'h77 ^ 8'h19, 8'h19};
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (a_if.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", a_if.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", a_if.in_ready); end
        checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", a_if.out_valid); end
        checks++; if (a_if.rnd_req !== 1'b0) begin errors++; $display("FAIL mid_rnd_req: got %b want 0", a_if.rnd_req); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", a_if.busy); end
        checks++; if (a_if.out_sh !== 16'h0000) begin errors++; $display("FAIL mid_out_sh: got %h want 0000", a_if.out_sh); end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL mid_partial: %0d spurious cycles want 0", spurious); end
        run_a(8'h00, 8'($urandom), 1'b0, 1'b0, sh, lat);
        checks++; if ((sh[15:8] ^ sh[7:0]) !== 8'h65) begin errors++; $display("FAIL mid_after: got %h want 65", sh[15:8] ^ sh[7:0]); end
    endtask

    task automatic test_rnd_zero();
        logic [15:0] sh0, sh1;
        logic [7:0]  x, m;
        int          lat;
        int          differ = 0;
        for (int t = 0; t < 4; t++) begin
            x = 8'(8'h13 + t * 61);
            m = 8'($urandom);
            run_a(x, m, 1'b1, 1'b0, sh0, lat);
            run_a(x, m, 1'b0, 1'b0, sh1, lat);
            checks++; if ((sh0[15:8] ^ sh0[7:0]) !== sbox_ref(x)) begin errors++; $display("FAIL rnd0_value x=%h: got %h want %h", x, sh0[15:8] ^ sh0[7:0], sbox_ref(x)); end
            checks++; if ((sh1[15:8] ^ sh1[7:0]) !== (sh0[15:8] ^ sh0[7:0])) begin errors++; $display("FAIL rnd_xor x=%h: got %h want %h", x, sh1[15:8] ^ sh1[7:0], sh0[15:8] ^ sh0[7:0]); end
            if (sh0 !== sh1) differ++;
        end
        checks++; if (differ == 0) begin errors++; $display("FAIL rnd_shares_differ: got %0d differing runs want >0", differ); end
    endtask

`ifdef SKINNY_SBOX_OUT_REFRESH_EN
    task automatic test_refresh();
        logic [15:0] sh0, sh1;
        int          lat;
        a_if.rnd_ref = 8'h00;
        run_a(8'hC6, 8'h3B, 1'b1, 1'b0, sh0, lat);
        a_if.rnd_ref = 8'h5A;
        run_a(8'hC6, 8'h3B, 1'b1, 1'b0, sh1, lat);
        a_if.rnd_ref = 8'h00;
        checks++; if (lat !== 8) begin errors++; $display("FAIL ref_latency: got %0d want 8", lat); end
        checks++; if ((sh1[15:8] ^ sh1[7:0]) !== sbox_ref(8'hC6)) begin errors++; $display("FAIL ref_xor: got %h want %h", sh1[15:8] ^ sh1[7:0], sbox_ref(8'hC6)); end
        checks++; if ((sh0 ^ sh1) !== 16'h5A5A) begin errors++; $display("FAIL ref_delta: got %h want 5a5a", sh0 ^ sh1); end
    endtask
`endif

    initial begin
        a_if.in_valid = 1'b0; a_if.in_sh = '0; a_if.rnd = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_sh = '0; b_if.rnd = '0; b_if.out_ready = 1'b0;
`ifdef SKINNY_SBOX_OUT_REFRESH_EN
        a_if.rnd_ref = '0;
        b_if.rnd_ref = '0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_lut_row();
        test_sweep();
        test_wide();
        test_backpressure();
        test_reset_mid();
        test_rnd_zero();
`ifdef SKINNY_SBOX_OUT_REFRESH_EN
        test_refresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
